// File: rtl/midi_voice_alloc.sv
// rtl/midi_voice_alloc.sv - MIDI event to synth voice slot allocator
// Fixed-latency round-robin scan of the voice table with retrigger and oldest-slot stealing.
module midi_voice_alloc #(
  parameter int NUM_VOICES = 128,
  parameter int ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ev_valid,
  output logic              ev_ready,
  input  logic [1:0]        ev_type,
  input  logic [3:0]        ev_channel,
  input  logic [6:0]        ev_note,
  input  logic [6:0]        ev_value,
  output logic              note_pressed,
  output logic              note_released,
  output logic              note_keypress,
  output logic              pitch_wheel,
  output logic [6:0]        note,
  output logic [6:0]        velocity,
  output logic [3:0]        channel,
  output logic [ADDR_W-1:0] addr,
  output logic              voice_stolen
);

  localparam int IDX_W = (NUM_VOICES > 2) ? $clog2(NUM_VOICES) : 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_VOICES - 1);
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

  localparam logic [1:0] T_ON    = 2'd0;
  localparam logic [1:0] T_OFF   = 2'd1;
  localparam logic [1:0] T_KEY   = 2'd2;
  localparam logic [1:0] T_PITCH = 2'd3;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SCAN = 2'd1, S_EMIT = 2'd2} state_t;

  state_t state_q, state_d;

  logic              ready_q, ready_d;
  logic [ADDR_W-1:0] k_q, k_d;
  logic [ADDR_W-1:0] j_q, j_d;
  logic [ADDR_W-1:0] aptr_q, aptr_d;
  logic              mfound_q, mfound_d;
  logic [ADDR_W-1:0] midx_q, midx_d;
  logic              ffound_q, ffound_d;
  logic [ADDR_W-1:0] fidx_q, fidx_d;
  logic [1:0]        etype_q, etype_d;
  logic [3:0]        ech_q, ech_d;
  logic [6:0]        enote_q, enote_d;
  logic [6:0]        eval_q, eval_d;

  logic              pressed_q, pressed_d;
  logic              released_q, released_d;
  logic              keypress_q, keypress_d;
  logic              pitch_q, pitch_d;
  logic              stolen_q, stolen_d;
  logic [6:0]        note_q, note_d;
  logic [6:0]        vel_q, vel_d;
  logic [3:0]        chan_q, chan_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic [NUM_VOICES-1:0] valid_q;
  logic [3:0]            tch_q   [NUM_VOICES];
  logic [6:0]            tnote_q [NUM_VOICES];

  logic              tw_en;
  logic              tw_set;
  logic [IDX_W-1:0]  tw_idx;
  logic [ADDR_W-1:0] slot;

  logic             accept;
  logic             last_scan;
  logic [IDX_W-1:0] j_idx;
  logic             hit;
  logic             vfree;

  assign accept    = (state_q == S_IDLE) && ev_valid && ready_q;
  assign last_scan = (state_q == S_SCAN) && (k_q == LAST);
  assign j_idx     = j_q[IDX_W-1:0];
  assign hit       = valid_q[j_idx] && (tch_q[j_idx] == ech_q) && (tnote_q[j_idx] == enote_q);
  assign vfree     = !valid_q[j_idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = (ev_type == T_PITCH) ? S_EMIT : S_SCAN;
      S_SCAN:  if (k_q == LAST) state_d = S_EMIT;
      S_EMIT:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Event latch and search bookkeeping; the scan index wraps at NUM_VOICES, not 2^ADDR_W.
  always_comb begin
    etype_d  = etype_q;
    ech_d    = ech_q;
    enote_d  = enote_q;
    eval_d   = eval_q;
    k_d      = k_q;
    j_d      = j_q;
    mfound_d = mfound_q;
    midx_d   = midx_q;
    ffound_d = ffound_q;
    fidx_d   = fidx_q;
    if (accept) begin
      etype_d  = (ev_type == T_ON && ev_value == 7'd0) ? T_OFF : ev_type;
      ech_d    = ev_channel;
      enote_d  = ev_note;
      eval_d   = ev_value;
      k_d      = '0;
      j_d      = aptr_q;
      mfound_d = 1'b0;
      midx_d   = '0;
      ffound_d = 1'b0;
      fidx_d   = '0;
    end else if (state_q == S_SCAN) begin
      k_d = k_q + ONE;
      j_d = (j_q == LAST) ? '0 : j_q + ONE;
      if (!mfound_q && hit) begin
        mfound_d = 1'b1;
        midx_d   = j_q;
      end
      if (!ffound_q && vfree) begin
        ffound_d = 1'b1;
        fidx_d   = j_q;
      end
    end
  end

  // Outputs are registered on the edge entering EMIT, so the last scan cycle folds in its own inspection.
  always_comb begin
    ready_d    = (state_d == S_IDLE);
    pressed_d  = 1'b0;
    released_d = 1'b0;
    keypress_d = 1'b0;
    pitch_d    = 1'b0;
    stolen_d   = 1'b0;
    note_d     = note_q;
    vel_d      = vel_q;
    chan_d     = chan_q;
    addr_d     = addr_q;
    aptr_d     = aptr_q;
    tw_en      = 1'b0;
    tw_set     = 1'b0;
    slot       = '0;
    if (accept && ev_type == T_PITCH) begin
      pitch_d = 1'b1;
      note_d  = ev_note;
      vel_d   = 7'd0;
      chan_d  = ev_channel;
      addr_d  = '0;
    end else if (last_scan) begin
      case (etype_q)
        T_ON: begin
          slot      = mfound_d ? midx_d : (ffound_d ? fidx_d : aptr_q);
          pressed_d = 1'b1;
          stolen_d  = !mfound_d && !ffound_d;
          note_d    = enote_q;
          vel_d     = eval_q;
          chan_d    = ech_q;
          addr_d    = slot;
          tw_en     = 1'b1;
          tw_set    = 1'b1;
          aptr_d    = (slot == LAST) ? '0 : slot + ONE;
        end
        T_OFF: begin
          if (mfound_d) begin
            slot       = midx_d;
            released_d = 1'b1;
            note_d     = enote_q;
            vel_d      = eval_q;
            chan_d     = ech_q;
            addr_d     = midx_d;
            tw_en      = 1'b1;
          end
        end
        T_KEY: begin
          if (mfound_d) begin
            keypress_d = 1'b1;
            note_d     = enote_q;
            vel_d      = eval_q;
            chan_d     = ech_q;
            addr_d     = midx_d;
          end
        end
        default: ;
      endcase
    end
  end

  assign tw_idx = slot[IDX_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_q    <= 1'b0;
      k_q        <= '0;
      j_q        <= '0;
      aptr_q     <= '0;
      mfound_q   <= 1'b0;
      midx_q     <= '0;
      ffound_q   <= 1'b0;
      fidx_q     <= '0;
      etype_q    <= T_ON;
      ech_q      <= 4'd0;
      enote_q    <= 7'd0;
      eval_q     <= 7'd0;
      pressed_q  <= 1'b0;
      released_q <= 1'b0;
      keypress_q <= 1'b0;
      pitch_q    <= 1'b0;
      stolen_q   <= 1'b0;
      note_q     <= 7'd0;
      vel_q      <= 7'd0;
      chan_q     <= 4'd0;
      addr_q     <= '0;
    end else begin
      ready_q    <= ready_d;
      k_q        <= k_d;
      j_q        <= j_d;
      aptr_q     <= aptr_d;
      mfound_q   <= mfound_d;
      midx_q     <= midx_d;
      ffound_q   <= ffound_d;
      fidx_q     <= fidx_d;
      etype_q    <= etype_d;
      ech_q      <= ech_d;
      enote_q    <= enote_d;
      eval_q     <= eval_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
      keypress_q <= keypress_d;
      pitch_q    <= pitch_d;
      stolen_q   <= stolen_d;
      note_q     <= note_d;
      vel_q      <= vel_d;
      chan_q     <= chan_d;
      addr_q     <= addr_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (tw_en) begin
      valid_q[tw_idx] <= tw_set;
    end
  end

  // Channel/note payload needs no reset: it is only trusted where the valid bit is set.
  always_ff @(posedge clk) begin
    if (tw_en && tw_set) begin
      tch_q[tw_idx]   <= ech_q;
      tnote_q[tw_idx] <= enote_q;
    end
  end

  assign ev_ready      = ready_q;
  assign note_pressed  = pressed_q;
  assign note_released = released_q;
  assign note_keypress = keypress_q;
  assign pitch_wheel   = pitch_q;
  assign voice_stolen  = stolen_q;
  assign note          = note_q;
  assign velocity      = vel_q;
  assign channel       = chan_q;
  assign addr          = addr_q;

endmodule
